hf_tans_multi_recoder: RTL and testbench

HF_TANS_MULTI_RECODER -- requirements
Module: hf_tans_multi_recoder

---
 rtl/hf_tans_multi_recoder.sv | 215 +++++++++++++++++++++
 tb/tb_hf_tans_multi_recoder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hf_tans_multi_recoder.sv
// Huffman-to-tANS recoder: gathers Huffman bits into symbols and re-encodes each one as tANS bits.
// Define HF_TANS_STATS_EN to add the sym_count/bit_count statistics outputs.
module hf_tans_multi_recoder #(
  parameter int unsigned R = 3,
  parameter int unsigned NSYM = 3,
  parameter int unsigned MAX_LEN = 2,
  localparam int unsigned L = 1 << R,
  localparam int unsigned CAW = $clog2(2 * NSYM + L),
  localparam int unsigned BW = $clog2(R + 1)
) (
  input  logic           PHI,
  input  logic           RST,
  input  logic           I_F,
  input  logic           i_valid,
  input  logic           i_stream,
  input  logic           i_last,
  output logic           i_ready,
  input  logic           cfg_we,
  input  logic [CAW-1:0] cfg_addr,
  input  logic [15:0]    cfg_data,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [BW-1:0]  BTR,
  output logic [R-1:0]   o_stream,
  output logic [R:0]     final_state,
  output logic           done,
`ifdef HF_TANS_STATS_EN
  output logic [15:0]    sym_count,
  output logic [15:0]    bit_count,
`endif
  output logic           err
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned SW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [R:0] LINIT = {1'b1, {R{1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StStall} state_e;

  state_e             state_q, state_d;
  logic [R:0]         x_q, x_d;
  logic [MAX_LEN-1:0] acc_q, acc_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ov_q, ov_d, done_q, done_d, err_q, err_d;
  logic [BW-1:0]      btr_q, btr_d;
  logic [R-1:0]       ostr_q, ostr_d;
  logic [R:0]         fin_q, fin_d;

  logic [15:0] huff_q [NSYM];
  logic [15:0] fc_q   [NSYM];
  logic [R:0]  enc_q  [L];

  logic               out_block, start, accept, hit;
  logic [R:0]         base_x, next_x;
  logic [MAX_LEN-1:0] base_acc, new_acc;
  logic [LW-1:0]      base_len, new_len;
  logic [SW-1:0]      sym;
  logic [7:0]         f, cum;
  int                 nb;
  logic [31:0]        shifted;
  logic [R-1:0]       emit, idx;

  // Tables are writable only while idle so a running block sees a stable map.
  always_ff @(posedge PHI or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NSYM; i++) begin
        huff_q[i] <= '0;
        fc_q[i]   <= '0;
      end
      for (int i = 0; i < L; i++) enc_q[i] <= '0;
    end else if (cfg_we && state_q == StIdle) begin
      for (int i = 0; i < NSYM; i++) begin
        if (cfg_addr == CAW'(i)) huff_q[i] <= cfg_data;
        if (cfg_addr == CAW'(NSYM + i)) fc_q[i] <= cfg_data;
      end
      for (int i = 0; i < L; i++) begin
        if (cfg_addr == CAW'(2 * NSYM + i)) enc_q[i] <= cfg_data[R:0];
      end
    end
  end

  always_comb begin
    out_block = ov_q && !o_ready;
    i_ready   = (state_q == StRun) && !out_block;
    start     = i_valid && I_F && !out_block && (state_q != StStall);
    accept    = start || (i_valid && i_ready);
    base_x    = start ? LINIT : x_q;
    base_acc  = start ? '0 : acc_q;
    base_len  = start ? '0 : len_q;
    new_acc   = (base_acc << 1) | MAX_LEN'(i_stream);
    new_len   = base_len + LW'(1);

    // Descending scan so the lowest matching symbol index wins.
    hit = 1'b0;
    sym = '0;
    for (int s = NSYM - 1; s >= 0; s--) begin
      if (huff_q[s][3:0] == 4'(new_len) && huff_q[s][15:4] == 12'(new_acc)) begin
        hit = 1'b1;
        sym = SW'(s);
      end
    end
    f   = fc_q[sym][7:0];
    cum = fc_q[sym][15:8];

    nb = R;
    for (int k = R; k >= 0; k--) begin
      if ((32'(base_x) >> k) < (32'(f) << 1)) nb = k;
    end
    shifted = 32'(base_x) >> nb;
    emit    = R'(32'(base_x) & ((32'd1 << nb) - 32'd1));
    idx     = R'(32'(cum) + shifted - 32'(f));
    next_x  = enc_q[idx];

    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    len_d   = len_q;
    ov_d    = ov_q && !o_ready;
    done_d  = 1'b0;
    err_d   = err_q;
    btr_d   = btr_q;
    ostr_d  = ostr_q;
    fin_d   = fin_q;

    if (accept) begin
      if (start) err_d = 1'b0;
      state_d = StRun;
      x_d     = base_x;
      acc_d   = new_acc;
      len_d   = new_len;
      if (hit) begin
        if (f == 8'd0) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          ov_d   = 1'b1;
          btr_d  = BW'(nb);
          ostr_d = emit;
          x_d    = next_x;
          acc_d  = '0;
          len_d  = '0;
          if (i_last) begin
            done_d  = 1'b1;
            fin_d   = next_x;
            state_d = StIdle;
          end
        end
      end else if (i_last || new_len == LW'(MAX_LEN)) begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
    end else if (state_q == StRun && out_block) begin
      state_d = StStall;
    end else if (state_q == StStall && o_ready) begin
      state_d = StRun;
    end
  end

  always_ff @(posedge PHI or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      x_q     <= '0;
      acc_q   <= '0;
      len_q   <= '0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      btr_q   <= '0;
      ostr_q  <= '0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
      err_q   <= err_d;
      btr_q   <= btr_d;
      ostr_q  <= ostr_d;
      fin_q   <= fin_d;
    end
  end

  assign o_valid     = ov_q;
  assign done        = done_q;
  assign err         = err_q;
  assign BTR         = btr_q;
  assign o_stream    = ostr_q;
  assign final_state = fin_q;

`ifdef HF_TANS_STATS_EN
  logic [15:0] sym_q, bit_q;
  logic [16:0] bit_sum;

  assign bit_sum = 17'(bit_q) + 17'(btr_q);

  always_ff @(posedge PHI or negedge RST) begin
    if (!RST) begin
      sym_q <= '0;
      bit_q <= '0;
    end else if (start) begin
      sym_q <= '0;
      bit_q <= '0;
    end else if (ov_q && o_ready) begin
      if (sym_q != 16'hFFFF) sym_q <= sym_q + 16'd1;
      bit_q <= bit_sum[16] ? 16'hFFFF : bit_sum[15:0];
    end
  end

  assign sym_count = sym_q;
  assign bit_count = bit_q;
`endif

endmodule

// File: tb/tb_hf_tans_multi_recoder.sv
// Scoreboard bench for hf_tans_multi_recoder: directed Huffman streams with hand-computed outputs.
module tb_hf_tans_multi_recoder;
  logic        PHI = 1'b0;
  logic        RST = 1'b1;
  logic        I_F = 1'b0, i_valid = 1'b0, i_stream = 1'b0, i_last = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        o_ready = 1'b1;
  logic        i_ready, o_valid, done, err;
  logic [1:0]  BTR;
  logic [2:0]  o_stream;
  logic [3:0]  final_state;
`ifdef HF_TANS_STATS_EN
  logic [15:0] sym_count, bit_count;
`endif

  hf_tans_multi_recoder #(.R(3), .NSYM(3), .MAX_LEN(2)) dut (
    .PHI(PHI), .RST(RST), .I_F(I_F), .i_valid(i_valid), .i_stream(i_stream),
    .i_last(i_last), .i_ready(i_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .o_valid(o_valid), .o_ready(o_ready), .BTR(BTR),
    .o_stream(o_stream), .final_state(final_state), .done(done),
`ifdef HF_TANS_STATS_EN
    .sym_count(sym_count), .bit_count(bit_count),
`endif
    .err(err)
  );

  always #5 PHI = ~PHI;

  typedef struct packed {
    logic [1:0] btr;
    logic [2:0] str;
    logic       dn;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0, bad = 0;
  int   out_idx = 0, stall_at = -1, stall_left = 0, stall_seen = 0;
  logic done_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int b, input int s, input int d);
    exp_t x;
    x.btr = 2'(b);
    x.str = 3'(s);
    x.dn  = 1'(d);
    q.push_back(x);
  endtask

  // Back-pressure generator: holds o_ready low for stall_left cycles at output number stall_at.
  always @(negedge PHI) begin
    if (o_valid && out_idx == stall_at && stall_left > 0) begin
      o_ready = 1'b0;
      stall_left--;
    end else begin
      o_ready = 1'b1;
    end
  end

  always @(negedge PHI) begin
    #2;
    if (RST) begin
      if (done) check("done_with_valid", int'(o_valid), 1);
      if (o_valid) begin
        if (done) done_seen = 1'b1;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: BTR=%0d o_stream=%0d, expected no output",
                   BTR, o_stream);
        end else if (!o_ready) begin
          stall_seen++;
          check("stall_i_ready", int'(i_ready), 0);
          check("stall_btr_hold", int'(BTR), int'(q[0].btr));
          check("stall_str_hold", int'(o_stream), int'(q[0].str));
        end else begin
          e = q.pop_front();
          check("out_btr", int'(BTR), int'(e.btr));
          check("out_stream", int'(o_stream), int'(e.str));
          check("out_done", int'(done_seen), int'(e.dn));
          done_seen = 1'b0;
          out_idx++;
        end
      end
    end
  end

  task automatic beat(input logic f, input logic b, input logic last);
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge PHI);
      I_F = f;
      i_valid = 1'b1;
      i_stream = b;
      i_last = last;
      #1;
      if (f || i_ready) begin
        @(posedge PHI);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got no accept, expected accept within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    @(negedge PHI);
    I_F = 1'b0;
    i_valid = 1'b0;
    i_last = 1'b0;
    repeat (n) @(negedge PHI);
  endtask

  task automatic cfg_write(input int a, input int d);
    @(negedge PHI);
    I_F = 1'b0;
    i_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_addr = 4'(a);
    cfg_data = 16'(d);
    @(posedge PHI);
    #1 cfg_we = 1'b0;
  endtask

  // A=0, B=10, C=11; F=4,2,2; Cum=0,4,6; enc[i]=8+i.
  task automatic config_s1();
    cfg_write(0, 16'h0001);
    cfg_write(1, 16'h0022);
    cfg_write(2, 16'h0032);
    cfg_write(3, 16'h0004);
    cfg_write(4, 16'h0402);
    cfg_write(5, 16'h0602);
    for (int i = 0; i < 8; i++) cfg_write(6 + i, 8 + i);
  endtask

  // A,B,C,A: x 8->8->12->15->11.
  task automatic run_s1();
    push(1, 0, 0);
    push(2, 0, 0);
    push(2, 0, 0);
    push(1, 1, 1);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b1);
    idle(6);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_o_valid"}, int'(o_valid), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_i_ready"}, int'(i_ready), 0);
    check({tag, "_btr"}, int'(BTR), 0);
    check({tag, "_o_stream"}, int'(o_stream), 0);
    check({tag, "_final_state"}, int'(final_state), 0);
  endtask

  initial begin
    #1 RST = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge PHI);
    RST = 1'b1;

    // Basic stream.
    config_s1();
    run_s1();
    check("s1_drained", q.size(), 0);
    check("s1_final_state", int'(final_state), 11);
    check("s1_err", int'(err), 0);
`ifdef HF_TANS_STATS_EN
    check("s6_sym_count", int'(sym_count), 4);
    check("s6_bit_count", int'(bit_count), 6);
`endif

    // Back-pressure on the second output.
    stall_at = out_idx + 1;
    stall_left = 3;
    stall_seen = 0;
    run_s1();
    check("s2_stall_cycles", stall_seen, 3);
    check("s2_drained", q.size(), 0);
    check("s2_final_state", int'(final_state), 11);

    // Unmatched two-bit codeword.
    cfg_write(0, 16'h0002);
    cfg_write(1, 16'h0012);
    cfg_write(2, 16'h0000);
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    #1 check("s3_err", int'(err), 1);
    check("s3_idle_i_ready", int'(i_ready), 0);
    idle(4);
    check("s3_no_valid", int'(o_valid), 0);
    check("s3_drained", q.size(), 0);

    // Reset mid-block, then prove tables cleared and the block recovers.
    config_s1();
    push(1, 0, 0);
    push(2, 0, 0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    @(negedge PHI);
    #3 RST = 1'b0;
    i_valid = 1'b0;
    #1 check_reset_outputs("s4_reset");
    done_seen = 1'b0;
    repeat (2) @(negedge PHI);
    RST = 1'b1;
    check("s4_drained", q.size(), 0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    #1 check("s4_empty_table_err", int'(err), 1);
    idle(3);
    config_s1();
    run_s1();
    check("s4_drained_after", q.size(), 0);
    check("s4_final_state", int'(final_state), 11);
    check("s4_err_cleared", int'(err), 0);

    // Restart mid-codeword; the enc write during RUN must be ignored.
    push(1, 0, 0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    push(1, 0, 0);
    push(2, 0, 0);
    push(2, 0, 0);
    push(1, 1, 1);
    beat(1'b1, 1'b0, 1'b0);
    cfg_write(9, 9);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b0, 1'b0, 1'b1);
    idle(6);
    check("s5_drained", q.size(), 0);
    check("s5_final_state", int'(final_state), 11);
    check("s5_err", int'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
